// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator with registered pixel output stage.
//   Clock, Reset          system clock, synchronous active-high reset
//   iEnable               raster run enable (low clears the raster and blanks the pins)
//   iRGB                  {R,G,B} colour for the pixel currently shown on (oCol,oRow)
//   oCol, oRow            registered raster counters (pixel request coordinates)
//   oPixelValid           (oCol,oRow) lies inside the visible area
//   oLineStart            one-Clock pulse when the column wraps to 0
//   oFrameStart           one-Clock pulse when the raster wraps to (0,0)
//   VGA_RED/GREEN/BLUE    registered pixel colour
//   VGA_HSYNC, VGA_VSYNC  registered syncs, active level SYNC_POL
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter int unsigned CLK_DIV   = 2,
    parameter bit          SYNC_POL  = 1'b0,
    parameter int unsigned COLOR_W   = 1,
    parameter int unsigned CNT_W     = 10
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 iEnable,
    input  logic [3*COLOR_W-1:0] iRGB,
    output logic [CNT_W-1:0]     oCol,
    output logic [CNT_W-1:0]     oRow,
    output logic                 oPixelValid,
    output logic                 oLineStart,
    output logic                 oFrameStart,
    output logic [COLOR_W-1:0]   VGA_RED,
    output logic [COLOR_W-1:0]   VGA_GREEN,
    output logic [COLOR_W-1:0]   VGA_BLUE,
    output logic                 VGA_HSYNC,
    output logic                 VGA_VSYNC
);

    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(V_TOTAL - 1);

    logic [DIV_W-1:0] divCnt;
    logic             pixTick;
    logic             colWrap;
    logic             rowWrap;
    logic             visible;
    logic             hActive;
    logic             vActive;

    // Decode from the current (pre-tick) counters; the output stage latches these on the tick.
    assign pixTick = iEnable && (divCnt == DIV_LAST);
    assign colWrap = (oCol == COL_LAST);
    assign rowWrap = (oRow == ROW_LAST);
    assign visible = (32'(oCol) < H_VISIBLE) && (32'(oRow) < V_VISIBLE);
    assign hActive = (32'(oCol) >= HS_START) && (32'(oCol) < HS_END);
    assign vActive = (32'(oRow) >= VS_START) && (32'(oRow) < VS_END);

    assign oPixelValid = visible;

    // Pixel divider and raster counters; disable parks the raster at (0,0).
    always_ff @(posedge Clock) begin
        if (Reset || !iEnable) begin
            divCnt <= '0;
            oCol   <= '0;
            oRow   <= '0;
        end else if (pixTick) begin
            divCnt <= '0;
            if (colWrap) begin
                oCol <= '0;
                oRow <= rowWrap ? '0 : oRow + CNT_W'(1);
            end else begin
                oCol <= oCol + CNT_W'(1);
            end
        end else begin
            divCnt <= divCnt + DIV_W'(1);
        end
    end

    // Output stage: colour and syncs share one register stage so they stay aligned.
    always_ff @(posedge Clock) begin
        if (Reset || !iEnable) begin
            VGA_RED     <= '0;
            VGA_GREEN   <= '0;
            VGA_BLUE    <= '0;
            VGA_HSYNC   <= ~SYNC_POL;
            VGA_VSYNC   <= ~SYNC_POL;
            oLineStart  <= 1'b0;
            oFrameStart <= 1'b0;
        end else begin
            oLineStart  <= pixTick && colWrap;
            oFrameStart <= pixTick && colWrap && rowWrap;
            if (pixTick) begin
                {VGA_RED, VGA_GREEN, VGA_BLUE} <= visible ? iRGB : '0;
                VGA_HSYNC <= hActive ? SYNC_POL : ~SYNC_POL;
                VGA_VSYNC <= vActive ? SYNC_POL : ~SYNC_POL;
            end
        end
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator and pixel output stage for the MiniAlu display path. It replaces a fixed 640x480 sync scheme and adds:
- configurable porch and sync timing, clock division and sync polarity;
- per-channel colour width;
- pixel-coordinate request outputs, so upstream logic supplies colour for each pixel.

VGA outputs are fully registered and aligned with each other, and sit directly on the board pins.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 2, Clock cycles per pixel (≥1)
- SYNC_POL, 0, active sync level (0 = active-low)
- COLOR_W, 1, bits per colour channel
- CNT_W, 10, coordinate counter width; H_TOTAL and V_TOTAL must each be ≤ 2^CNT_W

Ports:
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- iEnable  in  1  raster run enable
- iRGB  in  3*COLOR_W  colour for pixel (oCol,oRow), packed {R,G,B}
- oCol  out  CNT_W  current horizontal counter
- oRow  out  CNT_W  current vertical counter
- oPixelValid  out  1  (oCol,oRow) lies in the visible area
- oLineStart  out  1  one-Clock pulse when the column wraps to 0
- oFrameStart  out  1  one-Clock pulse when the raster wraps to (0,0)
- VGA_RED, VGA_GREEN, VGA_BLUE  out  COLOR_W each  pixel colour
- VGA_HSYNC, VGA_VSYNC  out  1  sync outputs

## Operation
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (default 800). V_TOTAL is formed the same way (default 525).
- Divider: counts 0..CLK_DIV-1. The pixel tick is asserted when the divider equals CLK_DIV-1. With CLK_DIV=1 the tick is asserted every cycle.
- On each tick:
  - col increments. When col = H_TOTAL-1 it wraps to 0 and row increments.
  - row wraps to 0 after V_TOTAL-1.
- oCol/oRow are the registered counters. oPixelValid = (col<H_VISIBLE)&&(row<V_VISIBLE).
- HSYNC is active for H_VISIBLE+H_FRONT ≤ col < H_VISIBLE+H_FRONT+H_SYNC. VSYNC uses the same rule on row. Active level = SYNC_POL; inactive level = ~SYNC_POL.
- Output stage, updated on each tick from the pre-tick counters:
  - colour = iRGB if pixel valid, else 0;
  - syncs are decoded from the same counters, so colour and syncs stay aligned.
- oLineStart: high for the single Clock where col becomes 0.
- oFrameStart: high for the single Clock where (col,row) becomes (0,0).
- iEnable low:
  - next Clock: divider, col and row are cleared to 0;
  - colours are 0 and syncs are inactive;
  - oLineStart and oFrameStart stay low.
- iEnable rising: the raster restarts at (0,0). No start pulses are emitted for this restart; the first oFrameStart comes at the next natural wrap.
- Reset overrides iEnable and takes effect at any point in the frame.

## Timing
- Reset values (one Clock after Reset is sampled high):
  - divider, col, row = 0;
  - colours = 0;
  - syncs inactive;
  - oLineStart = oFrameStart = 0;
  - oPixelValid = 1 (combinational on counters (0,0)).
- First tick occurs CLK_DIV Clocks after Reset is released with iEnable high.
- iRGB is sampled on the tick Clock edge while (oCol,oRow) shows the requested pixel. It appears on the VGA pins immediately after that edge and holds for CLK_DIV Clocks. The upstream lookup therefore has CLK_DIV Clocks per pixel.
- Line period = H_TOTAL*CLK_DIV Clocks. Frame period = H_TOTAL*V_TOTAL*CLK_DIV Clocks. Defaults: 1600 and 840000 Clocks.
- HSYNC pulse = H_SYNC*CLK_DIV Clocks (default 192). VSYNC pulse = V_SYNC*H_TOTAL*CLK_DIV Clocks (default 3200).
- Row changes on the same tick as the column wrap. There is no extra cycle at line or frame wrap.
- Simultaneous column wrap and row wrap: oLineStart and oFrameStart pulse in the same Clock.

## Test plan
- Reset with defaults, iEnable=1: outputs at reset values, then oCol=1 after 2 Clocks. VGA_HSYNC=1 and VGA_VSYNC=1 while inactive.
- Defaults, free-run one frame:
  - HSYNC low for 192 Clocks, period 1600;
  - VSYNC low for 3200 Clocks, period 840000;
  - exactly 525 oLineStart pulses and 1 oFrameStart pulse per frame.
- iRGB=3'b101 held constant:
  - pins read R=1,G=0,B=1 only during visible pixels;
  - iRGB=3'b111 during blanking (col ≥ 640 or row ≥ 480) gives pins 0.
- Drop iEnable at col=300,row=10: next Clock has counters 0, colours 0 and syncs inactive. Re-raise: the first tick shows oCol=1 with no oFrameStart.
- Small config with H 4/1/1/1, V 3/1/1/1, CLK_DIV=1, SYNC_POL=1, COLOR_W=2:
  - HSYNC high only at col 5; VSYNC high only during row 4;
  - wrap from (6,5) to (0,0) gives oLineStart and oFrameStart in the same Clock.
- Assert Reset at row 200: the next Clock shows all reset values, and the raster resumes from (0,0).
